// File: rtl/conv_pkg.sv
// Shared definitions for the ConvPE output side: default widths, collector
// FSM encoding and the signed saturation helper.
package conv_pkg;

    localparam int unsigned DWIDTH   = 16;
    localparam int unsigned AWIDTH   = 24;
    localparam int unsigned MAX_FMAP = 28;

    typedef enum logic [1:0] {
        COLL_IDLE     = 2'd0,
        COLL_WAIT_SOP = 2'd1,
        COLL_COLLECT  = 2'd2,
        COLL_DONE     = 2'd3
    } coll_state_e;

    // Clamp a signed value into the range of a w-bit two's complement number.
    function automatic logic signed [63:0] sat_to_dwidth(
        input logic signed [63:0] v,
        input int unsigned        w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) begin
            return hi;
        end
        if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/psum_ram.sv
// Partial-sum buffer: one write port, one synchronous read port.
// Read-during-write to the same address returns the old contents.
module psum_ram #(
    parameter int unsigned depth  = 676,
    parameter int unsigned width  = 24,
    parameter int unsigned addr_w = 10
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [addr_w-1:0] wr_addr,
    input  logic [width-1:0]  wr_data,
    input  logic [addr_w-1:0] rd_addr,
    output logic [width-1:0]  rd_data
);

    logic [width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/conv_out_collector.sv
// Collects the raw ConvPE result stream, accumulates over input channels and
// emits biased / ReLU'd / saturated output pixels into the output FIFO.
module conv_out_collector
    import conv_pkg::*;
#(
    parameter int unsigned dwidth   = DWIDTH,
    parameter int unsigned awidth   = AWIDTH,
    parameter int unsigned max_fmap = MAX_FMAP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [4:0]               featmap_size,
    input  logic [3:0]               in_ch,
    input  logic signed [dwidth-1:0] bias,
    input  logic                     relu_en,
    input  logic                     pe_adv,
    input  logic signed [dwidth-1:0] pe_dout,
    input  logic                     pe_dout_start,
    input  logic                     out_full,
    output logic                     out_wr_en,
    output logic [dwidth-1:0]        out_data,
    output logic                     pe_hold,
    output logic                     busy,
    output logic                     done
);

    localparam int unsigned DEPTH  = (max_fmap - 2) * (max_fmap - 2);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned VW     = awidth + 2;

    coll_state_e state_q;
    coll_state_e state_d;

    logic [4:0]               n_q;
    logic [4:0]               m_q;
    logic [3:0]               in_ch_q;
    logic signed [dwidth-1:0] bias_q;
    logic                     relu_q;
    logic [4:0]               fs_clamped;

    logic [3:0]        ch_cnt_q, ch_cnt_d;
    logic [4:0]        row_q, row_d;
    logic [4:0]        col_q, col_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              last_seen_q, last_seen_d;

    logic start_ok;
    logic accept;
    logic last_ch;
    logic col_ok;
    logic final_smp;

    logic                     ram_we;
    logic signed [awidth-1:0] ram_wd;
    logic [awidth-1:0]        ram_rd;
    logic                     fwd_q;
    logic signed [awidth-1:0] fwd_data_q;
    logic signed [awidth-1:0] psum_old;
    logic signed [awidth-1:0] psum_base;

    logic signed [VW-1:0]     v_sum;
    logic signed [VW-1:0]     v_relu;
    logic signed [63:0]       v_sat;
    logic                     res_valid;
    logic [dwidth-1:0]        res_data;

    logic              o_valid_q;
    logic [dwidth-1:0] o_data_q;
    logic              s_valid_q;
    logic [dwidth-1:0] s_data_q;
    logic              fire;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Sample qualification and position decode
    assign start_ok  = (state_q == COLL_IDLE) && start;
    assign accept    = pe_adv && (((state_q == COLL_WAIT_SOP) && pe_dout_start) ||
                                  ((state_q == COLL_COLLECT) && !last_seen_q));
    assign last_ch   = (ch_cnt_q == (in_ch_q - 4'd1));
    assign col_ok    = (col_q < m_q);
    assign final_smp = (row_q == (m_q - 5'd1)) && (col_q == (m_q - 5'd1));

    assign fs_clamped = (featmap_size < 5'd3)             ? 5'd3 :
                        (featmap_size > 5'(max_fmap))     ? 5'(max_fmap) :
                        featmap_size;

    // Map configuration, captured on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q     <= 5'd0;
            m_q     <= 5'd0;
            in_ch_q <= 4'd1;
            bias_q  <= '0;
            relu_q  <= 1'b0;
        end else if (start_ok) begin
            n_q     <= fs_clamped;
            m_q     <= fs_clamped - 5'd2;
            in_ch_q <= (in_ch == 4'd0) ? 4'd1 : in_ch;
            bias_q  <= bias;
            relu_q  <= relu_en;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state; the last channel lingers in COLLECT until output drains
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            COLL_IDLE: begin
                if (start) begin
                    state_d = COLL_WAIT_SOP;
                end
            end
            COLL_WAIT_SOP: begin
                if (accept) begin
                    state_d = (final_smp && !last_ch) ? COLL_WAIT_SOP : COLL_COLLECT;
                end
            end
            COLL_COLLECT: begin
                if (accept && final_smp && !last_ch) begin
                    state_d = COLL_WAIT_SOP;
                end else if (last_seen_q && !o_valid_q && !s_valid_q) begin
                    state_d = COLL_DONE;
                end
            end
            COLL_DONE: begin
                state_d = COLL_IDLE;
            end
            default: begin
                state_d = COLL_IDLE;
            end
        endcase
    end

    // FSM outputs, decoded from the next state so they register in step with it
    always_comb begin
        busy_d = 1'b0;
        done_d = 1'b0;
        if ((state_d == COLL_WAIT_SOP) || (state_d == COLL_COLLECT)) begin
            busy_d = 1'b1;
        end
        if (state_d == COLL_DONE) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    // Row/column/address/channel counters
    always_comb begin
        ch_cnt_d    = ch_cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        addr_d      = addr_q;
        last_seen_d = last_seen_q;
        if (start_ok) begin
            ch_cnt_d    = 4'd0;
            row_d       = 5'd0;
            col_d       = 5'd0;
            addr_d      = '0;
            last_seen_d = 1'b0;
        end else if (accept) begin
            if (col_q == (n_q - 5'd1)) begin
                col_d = 5'd0;
                row_d = row_q + 5'd1;
            end else begin
                col_d = col_q + 5'd1;
            end
            if (col_ok) begin
                addr_d = addr_q + ADDR_W'(1);
            end
            if (final_smp) begin
                row_d  = 5'd0;
                col_d  = 5'd0;
                addr_d = '0;
                if (last_ch) begin
                    last_seen_d = 1'b1;
                end else begin
                    ch_cnt_d = ch_cnt_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_cnt_q    <= 4'd0;
            row_q       <= 5'd0;
            col_q       <= 5'd0;
            addr_q      <= '0;
            last_seen_q <= 1'b0;
        end else begin
            ch_cnt_q    <= ch_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            addr_q      <= addr_d;
            last_seen_q <= last_seen_d;
        end
    end

    // The RAM is read one cycle ahead at the next address, so the old psum is
    // ready when the sample for that address is accepted.
    psum_ram #(
        .depth  (DEPTH),
        .width  (awidth),
        .addr_w (ADDR_W)
    ) u_psum_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .wr_addr (addr_q),
        .wr_data (ram_wd),
        .rd_addr (addr_d),
        .rd_data (ram_rd)
    );

    // Forward a write that collides with the lookahead read (1x1 output maps)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            fwd_q      <= ram_we && (addr_q == addr_d);
            fwd_data_q <= ram_wd;
        end
    end

    assign psum_old  = fwd_q ? fwd_data_q : $signed(ram_rd);
    assign psum_base = (ch_cnt_q == 4'd0) ? '0 : psum_old;

    assign ram_we = accept && col_ok && !last_ch;
    assign ram_wd = psum_base + awidth'(pe_dout);

    // Final-channel result: bias, optional ReLU, saturate
    always_comb begin
        v_sum     = VW'(psum_base) + VW'(pe_dout) + VW'(bias_q);
        v_relu    = (relu_q && v_sum[VW-1]) ? '0 : v_sum;
        v_sat     = sat_to_dwidth(64'(v_relu), dwidth);
        res_data  = dwidth'(v_sat);
        res_valid = accept && col_ok && last_ch;
    end

    // Output register plus one-entry skid for the sample caught by a late hold
    assign fire = o_valid_q && !out_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
        end else if (!o_valid_q || fire) begin
            if (s_valid_q) begin
                o_valid_q <= 1'b1;
                o_data_q  <= s_data_q;
                s_valid_q <= res_valid;
                if (res_valid) begin
                    s_data_q <= res_data;
                end
            end else begin
                o_valid_q <= res_valid;
                if (res_valid) begin
                    o_data_q <= res_data;
                end
            end
        end else if (res_valid) begin
            s_valid_q <= 1'b1;
            s_data_q  <= res_data;
        end
    end

    assign out_wr_en = fire;
    assign out_data  = o_data_q;
    assign pe_hold   = s_valid_q || ((state_q == COLL_COLLECT) && last_ch && out_full);
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_out_collector.sv
// Directed bench for conv_out_collector: maps are streamed by a small PE
// model that honours pe_hold one cycle late; FIFO writes are captured and compared.
module tb_conv_out_collector;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [4:0]         featmap_size;
    logic [3:0]         in_ch;
    logic signed [15:0] bias;
    logic               relu_en;
    logic               pe_adv;
    logic signed [15:0] pe_dout;
    logic               pe_dout_start;
    logic               out_full;
    logic               out_wr_en;
    logic [15:0]        out_data;
    logic               pe_hold;
    logic               busy;
    logic               done;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] wr_q [$];
    int          full_viol    = 0;
    int          adv_timeouts = 0;
    logic        hold_seen    = 1'b0;
    int          full_left    = 0;
    bit          bp_arm       = 1'b0;

    logic [15:0] exp_ramp [9] = '{16'd1, 16'd2, 16'd3, 16'd6, 16'd7, 16'd8, 16'd11, 16'd12, 16'd13};

    always #5 clk = ~clk;

    conv_out_collector dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .featmap_size  (featmap_size),
        .in_ch         (in_ch),
        .bias          (bias),
        .relu_en       (relu_en),
        .pe_adv        (pe_adv),
        .pe_dout       (pe_dout),
        .pe_dout_start (pe_dout_start),
        .out_full      (out_full),
        .out_wr_en     (out_wr_en),
        .out_data      (out_data),
        .pe_hold       (pe_hold),
        .busy          (busy),
        .done          (done)
    );

    // FIFO side: capture writes mid-cycle, when inputs and outputs are stable
    always @(negedge clk) begin
        hold_seen = pe_hold;
        if (out_wr_en) begin
            wr_q.push_back(out_data);
            if (out_full) begin
                full_viol++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock; also runs the out_full schedule of the back-pressure test
    task automatic tick();
        @(posedge clk);
        #1;
        if (full_left > 0) begin
            full_left--;
            if (full_left == 0) begin
                out_full = 1'b0;
            end
        end else if (bp_arm && (wr_q.size() >= 3)) begin
            bp_arm    = 1'b0;
            out_full  = 1'b1;
            full_left = 10;
            #1;
            check("hold_rise", 32'(pe_hold), 32'd1);
        end
    endtask

    // PE model: present a sample and advance once the collector is not holding
    task automatic send(input logic [15:0] d, input bit sop);
        bit ok;
        bit adv_now;
        ok            = 1'b0;
        pe_dout       = d;
        pe_dout_start = sop;
        for (int k = 0; k < 100; k++) begin
            pe_adv  = !hold_seen;
            adv_now = pe_adv;
            tick();
            if (adv_now) begin
                ok = 1'b1;
                break;
            end
        end
        pe_adv        = 1'b0;
        pe_dout_start = 1'b0;
        if (!ok) begin
            adv_timeouts++;
        end
    endtask

    task automatic start_map(input int n, input int ch, input logic [15:0] b, input bit relu);
        featmap_size = 5'(n);
        in_ch        = 4'(ch);
        bias         = b;
        relu_en      = relu;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    // Stream a whole map (last channel stops at the final valid sample) and wait for done
    task automatic run_map(input string tag, input int n, input int ch, input logic [15:0] b,
                           input bit relu, input bit const_mode, input logic [15:0] v0,
                           input logic [15:0] v1, input bit stall);
        int  m;
        int  nsmp;
        bit  seen;
        m    = n - 2;
        wr_q.delete();
        adv_timeouts = 0;
        start_map(n, ch, b, relu);
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int c = 0; c < ch; c++) begin
            nsmp = (m - 1) * n + m;
            for (int i = 0; i < nsmp; i++) begin
                send(const_mode ? ((c == 0) ? v0 : v1) : 16'(i + 1), i == 0);
                if (stall) begin
                    pe_dout = 16'hDEAD;
                    tick();
                end
            end
            if ((c == 0) && (ch > 1)) begin
                check({tag, "_ch0_nowrite"}, 32'(wr_q.size()), 32'd0);
            end
        end
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_done"}, 32'(seen), 32'd1);
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        check({tag, "_adv_bound"}, 32'(adv_timeouts), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    task automatic check_seq(input string tag, input logic [15:0] exp [9]);
        logic [15:0] got;
        check({tag, "_count"}, 32'(wr_q.size()), 32'd9);
        for (int i = 0; i < 9; i++) begin
            got = (i < wr_q.size()) ? wr_q[i] : 16'hxxxx;
            check($sformatf("%s_px%0d", tag, i), 32'(got), 32'(exp[i]));
        end
    endtask

    task automatic check_const(input string tag, input logic [15:0] val);
        logic [15:0] e [9];
        for (int i = 0; i < 9; i++) begin
            e[i] = val;
        end
        check_seq(tag, e);
    endtask

    initial begin
        rst_n         = 1'b0;
        start         = 1'b0;
        featmap_size  = 5'd0;
        in_ch         = 4'd0;
        bias          = 16'sd0;
        relu_en       = 1'b0;
        pe_adv        = 1'b0;
        pe_dout       = 16'sd0;
        pe_dout_start = 1'b0;
        out_full      = 1'b0;

        #12;
        check("rst_wr_en", 32'(out_wr_en), 32'd0);
        check("rst_data",  32'(out_data),  32'd0);
        check("rst_hold",  32'(pe_hold),   32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_done",  32'(done),      32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        run_map("single", 5, 1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        check_seq("single", exp_ramp);

        run_map("twoch", 5, 2, 16'h0010, 1'b0, 1'b1, 16'h0100, 16'hFF00, 1'b0);
        check_const("twoch", 16'h0010);

        run_map("satpos", 5, 3, 16'h0000, 1'b1, 1'b1, 16'h7000, 16'h7000, 1'b0);
        check_const("satpos", 16'h7FFF);

        run_map("relu", 5, 3, 16'h0000, 1'b1, 1'b1, 16'h9000, 16'h9000, 1'b0);
        check_const("relu", 16'h0000);

        run_map("satneg", 5, 3, 16'h0000, 1'b0, 1'b1, 16'h9000, 16'h9000, 1'b0);
        check_const("satneg", 16'h8000);

        run_map("stall", 5, 1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b1);
        check_seq("stall", exp_ramp);

        full_viol = 0;
        bp_arm    = 1'b1;
        run_map("bp", 5, 1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        check_seq("bp", exp_ramp);
        check("bp_armed_used", 32'(bp_arm), 32'd0);
        check("bp_wr_while_full", 32'(full_viol), 32'd0);

        // Abort a map partway with reset, then run a clean one
        wr_q.delete();
        start_map(5, 1, 16'h0000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            send(16'(i + 1), i == 0);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_wr_en", 32'(out_wr_en), 32'd0);
        check("midrst_data",  32'(out_data),  32'd0);
        check("midrst_hold",  32'(pe_hold),   32'd0);
        check("midrst_busy",  32'(busy),      32'd0);
        check("midrst_done",  32'(done),      32'd0);
        tick();
        rst_n = 1'b1;
        wr_q.delete();
        tick();
        tick();
        check("midrst_quiet", 32'(wr_q.size()), 32'd0);
        run_map("after_rst", 5, 1, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        check_seq("after_rst", exp_ramp);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
